div_unit: RTL and testbench

- Multi-cycle iterative divider attached to the execute stage; services DIV/DIVU.
- Execute stage launches a division with start_i, stalls the pipeline until ready_o, then writes result_o into HI/LO through its normal hi/lo write path.
- Result layout: remainder goes to HI, quotient goes to LO.
- One restoring-division step per clock; fixed latency, independent of operand values.

---
 rtl/div_unit.sv | 183 ++++++++++++++++++
 tb/tb_div_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// ============================================================================
// Module      : div_unit
// Description : Multi-cycle restoring divider for DIV/DIVU. One quotient bit
//               per clock, fixed latency. result_o = {remainder, quotient}.
//               Optional macro DIV_ZERO_FLAG_EN adds the divzero_o output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit #(
   parameter int DATA_W = 32
) (
   input  logic                  Clk,
   input  logic                  Rst_n,        // active-high synchronous reset
   input  logic                  signed_div_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   input  logic                  start_i,
   input  logic                  annul_i,
   output logic [2*DATA_W-1:0]   result_o,
   output logic                  ready_o
`ifdef DIV_ZERO_FLAG_EN
  ,output logic                  divzero_o
`endif
);

   localparam int CNT_W = $clog2(DATA_W) + 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_FREE   = 2'd0,
      S_BYZERO = 2'd1,
      S_ON     = 2'd2,
      S_END    = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [2*DATA_W-1:0]   work_q, work_d;     // {partial remainder, quotient}
   logic [DATA_W-1:0]     dvs_q, dvs_d;       // divisor magnitude
   logic                  negq_q, negq_d;     // quotient needs negation
   logic                  negr_q, negr_d;     // remainder needs negation
   logic [2*DATA_W-1:0]   result_q, result_d;
   logic                  ready_q, ready_d;
`ifdef DIV_ZERO_FLAG_EN
   logic                  divzero_q, divzero_d;
`endif

   // Operand magnitudes; the most negative value maps onto itself, which is
   // the correct unsigned magnitude.
   logic [DATA_W-1:0] abs1, abs2;
   assign abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
   assign abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

   // One restoring step: shift left, trial-subtract the divisor from the
   // (DATA_W+1)-bit upper part. Only the low DATA_W bits of a successful
   // difference are kept because the new remainder is always below the divisor.
   logic [DATA_W:0]     step_up;
   logic                step_ge;
   logic [DATA_W-1:0]   step_sub;
   logic [2*DATA_W-1:0] step_w;
   logic [DATA_W-1:0]   fin_q, fin_r;
   assign step_up  = {work_q[2*DATA_W-1:DATA_W], work_q[DATA_W-1]};
   assign step_ge  = (step_up >= {1'b0, dvs_q});
   assign step_sub = step_up[DATA_W-1:0] - dvs_q;
   assign step_w   = step_ge ? {step_sub, work_q[DATA_W-2:0], 1'b1}
                             : {step_up[DATA_W-1:0], work_q[DATA_W-2:0], 1'b0};
   assign fin_q    = negq_q ? -step_w[DATA_W-1:0] : step_w[DATA_W-1:0];
   assign fin_r    = negr_q ? -step_w[2*DATA_W-1:DATA_W] : step_w[2*DATA_W-1:DATA_W];

   // Next-state and datapath control; annul wins over start everywhere.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      work_d   = work_q;
      dvs_d    = dvs_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      result_d = result_q;
      ready_d  = ready_q;
`ifdef DIV_ZERO_FLAG_EN
      divzero_d = divzero_q;
`endif
      case (state_q)
         S_FREE: begin
            ready_d  = 1'b0;
            result_d = '0;
            cnt_d    = '0;
            if (start_i && !annul_i) begin
               dvs_d  = abs2;
               negq_d = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
               negr_d = signed_div_i && opdata1_i[DATA_W-1];
               work_d = {{DATA_W{1'b0}}, abs1};
               if (opdata2_i == '0) begin
                  state_d = S_BYZERO;
`ifdef DIV_ZERO_FLAG_EN
                  divzero_d = 1'b1;
`endif
               end else begin
                  state_d = S_ON;
               end
            end
         end
         S_ON: begin
            if (annul_i) begin
               state_d  = S_FREE;
               cnt_d    = '0;
               result_d = '0;
               ready_d  = 1'b0;
            end else begin
               work_d = step_w;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == C_LAST) begin
                  cnt_d    = '0;
                  result_d = {fin_r, fin_q};
                  ready_d  = 1'b1;
                  state_d  = S_END;
               end
            end
         end
         S_BYZERO: begin
            if (annul_i) begin
               state_d = S_FREE;
`ifdef DIV_ZERO_FLAG_EN
               divzero_d = 1'b0;
`endif
            end else begin
               state_d  = S_END;
               result_d = '0;
               ready_d  = 1'b1;
            end
         end
         default: begin // S_END
            if (annul_i || !start_i) begin
               state_d  = S_FREE;
               ready_d  = 1'b0;
               result_d = '0;
`ifdef DIV_ZERO_FLAG_EN
               divzero_d = 1'b0;
`endif
            end
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Rst_n) begin
         state_q  <= S_FREE;
         cnt_q    <= '0;
         work_q   <= '0;
         dvs_q    <= '0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
         divzero_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         work_q   <= work_d;
         dvs_q    <= dvs_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         result_q <= result_d;
         ready_q  <= ready_d;
`ifdef DIV_ZERO_FLAG_EN
         divzero_q <= divzero_d;
`endif
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;
`ifdef DIV_ZERO_FLAG_EN
   assign divzero_o = divzero_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module      : tb_div_unit
// Description : Self-checking bench for div_unit against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_unit;

   logic        Clk = 1'b0;
   logic        Rst_n = 1'b1;
   logic        signed_div_i = 1'b0;
   logic [31:0] opdata1_i = '0;
   logic [31:0] opdata2_i = '0;
   logic        start_i = 1'b0;
   logic        annul_i = 1'b0;
   logic [63:0] result_o;
   logic        ready_o;
`ifdef DIV_ZERO_FLAG_EN
   logic        divzero_o;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   div_unit #(.DATA_W(32)) dut (
      .Clk          (Clk),
      .Rst_n        (Rst_n),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
`ifdef DIV_ZERO_FLAG_EN
     ,.divzero_o    (divzero_o)
`endif
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
      end
   endtask

   // Reference: plain 64-bit integer division; SV truncates toward zero and
   // gives the remainder the dividend's sign, as DIV requires.
   function automatic logic [63:0] ref_div(input bit sd, input logic [31:0] a, input logic [31:0] b);
      longint na, nb, q, r;
      if (b == 32'd0) return 64'd0;
      if (sd) begin
         na = longint'($signed(a));
         nb = longint'($signed(b));
      end else begin
         na = longint'({32'd0, a});
         nb = longint'({32'd0, b});
      end
      q = na / nb;
      r = na % nb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Launch one division, check latency/result, hold start for 'hold'
   // extra cycles in END, then drop start and check the return to idle.
   task automatic do_div(input bit sd, input logic [31:0] a, input logic [31:0] b, input int hold);
      logic [63:0] exp;
      int edges;
      exp = ref_div(sd, a, b);
      signed_div_i = sd;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      tick();                      // E0: operands captured here
      opdata1_i    = $urandom;     // later changes must be ignored
      opdata2_i    = $urandom;
      signed_div_i = ~sd;
      edges = 0;
      while (!ready_o && edges < 60) begin
         tick();
         edges++;
      end
      chk("latency", 64'(edges + 1), (b == 32'd0) ? 64'd2 : 64'd33);
      chk("result", result_o, exp);
`ifdef DIV_ZERO_FLAG_EN
      chk("divzero", 64'(divzero_o), (b == 32'd0) ? 64'd1 : 64'd0);
`endif
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_ready", 64'(ready_o), 64'd1);
         chk("hold_result", result_o, exp);
      end
      start_i = 1'b0;
      tick();
      chk("drop_ready", 64'(ready_o), 64'd0);
      chk("drop_result", result_o, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
      chk("drop_divzero", 64'(divzero_o), 64'd0);
`endif
   endtask

   // Count ready_o pulses over a window to prove the unit stays idle.
   task automatic idle_window(input string tag, input int n);
      int seen;
      seen = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (ready_o) seen++;
      end
      chk(tag, 64'(seen), 64'd0);
   endtask

   initial begin
      logic [31:0] a, b;
      bit sd;
      int sel;

      repeat (2) tick();
      chk("rst_ready", 64'(ready_o), 64'd0);
      chk("rst_result", result_o, 64'd0);
      Rst_n = 1'b0;
      tick();

      // Directed cases
      do_div(1'b0, 32'd100, 32'd7, 2);
      do_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 0);
      do_div(1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 0);
      do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      do_div(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
      do_div(1'b0, 32'd1234, 32'd0, 1);
      do_div(1'b1, 32'h8000_0000, 32'd0, 0);
      do_div(1'b1, 32'h8000_0000, 32'h8000_0000, 0);
      do_div(1'b1, 32'd5, 32'h8000_0000, 0);

      // Annul mid-operation
      signed_div_i = 1'b0;
      opdata1_i    = 32'd100;
      opdata2_i    = 32'd7;
      start_i      = 1'b1;
      tick();
      repeat (10) tick();
      annul_i = 1'b1;
      start_i = 1'b0;
      tick();
      annul_i = 1'b0;
      chk("annul_ready", 64'(ready_o), 64'd0);
      chk("annul_result", result_o, 64'd0);
      idle_window("annul_noready", 40);
      do_div(1'b0, 32'd9, 32'd3, 0);

      // Reset mid-operation
      signed_div_i = 1'b1;
      opdata1_i    = 32'hFFFF_0000;
      opdata2_i    = 32'd3;
      start_i      = 1'b1;
      tick();
      repeat (20) tick();
      Rst_n   = 1'b1;
      start_i = 1'b0;
      tick();
      Rst_n = 1'b0;
      chk("midrst_ready", 64'(ready_o), 64'd0);
      chk("midrst_result", result_o, 64'd0);
      idle_window("midrst_noready", 40);

      // Long hold in END
      do_div(1'b1, 32'hFFFF_FF9C, 32'd7, 6);

      // Randomized operands with emphasis on corner divisors
      for (int k = 0; k < 30; k++) begin
         sd  = 1'($urandom_range(0, 1));
         a   = $urandom;
         sel = int'($urandom_range(0, 7));
         case (sel)
            0:       b = 32'd0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = 32'd1;
            3:       b = 32'($urandom_range(1, 16));
            4:       b = 32'h8000_0000;
            default: b = $urandom;
         endcase
         if (sel == 5) a = 32'h8000_0000;
         do_div(sd, a, b, int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
